// File: rtl/g2b_serial_decoder.sv
// Serial Gray-to-binary decoder: resolves one bit per clock, MSB first, between valid/ready handshakes.
// Optional G2B_STEP_CHECK_EN adds step_err, flagging accepted words that differ from the previous one in 2+ bits.
module g2b_serial_decoder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_binary,
`ifdef G2B_STEP_CHECK_EN
  output logic             step_err,
`endif
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = WIDTH - 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             in_ready_d, out_valid_d, busy_d;
  logic [WIDTH-1:0] out_binary_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_bit;

`ifdef G2B_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic             step_err_d;
  logic [5:0]       step_pop;

  // Hamming distance between the offered word and the last accepted one
  always_comb begin
    step_pop = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      step_pop = step_pop + 6'(in_gray[i] ^ prev_q[i]);
    end
  end
`endif

  // acc_q[0] holds the previously resolved bit (0 before the MSB), gray_q[MSB] the next Gray bit
  assign res_bit = acc_q[0] ^ gray_q[WIDTH-1];

  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready;
    out_valid_d  = out_valid;
    out_binary_d = out_binary;
    gray_d       = gray_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
`ifdef G2B_STEP_CHECK_EN
    prev_d       = prev_q;
    have_prev_d  = have_prev_q;
    step_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          gray_d     = in_gray;
          acc_d      = '0;
          cnt_d      = CNT_W'(WIDTH - 1);
          in_ready_d = 1'b0;
          state_d    = CONV;
`ifdef G2B_STEP_CHECK_EN
          step_err_d  = have_prev_q && (step_pop >= 6'd2);
          prev_d      = in_gray;
          have_prev_d = 1'b1;
`endif
        end else begin
          in_ready_d = 1'b1;
        end
      end
      CONV: begin
        acc_d  = ACC_W'({acc_q, res_bit});
        gray_d = {gray_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
          out_binary_d = {acc_q, res_bit};
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d == CONV) || (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_binary  <= '0;
      busy        <= 1'b0;
      gray_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`ifdef G2B_STEP_CHECK_EN
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      step_err    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      out_binary  <= out_binary_d;
      busy        <= busy_d;
      gray_q      <= gray_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
`ifdef G2B_STEP_CHECK_EN
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      step_err    <= step_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_g2b_serial_decoder.sv
// Self-checking bench for g2b_serial_decoder: directed scenarios plus randomized words against a Gray reference model.
module tb_g2b_serial_decoder;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_gray;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_binary;
  logic         busy;
`ifdef G2B_STEP_CHECK_EN
  logic         step_err;
  logic [W-1:0] prev_g;
  bit           have_prev;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;

  g2b_serial_decoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gray   (in_gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_binary(out_binary),
`ifdef G2B_STEP_CHECK_EN
    .step_err  (step_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: binary is the XOR of the Gray word with all of its right shifts
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < int'(W); s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a word until it is taken; returns at #1 after the acceptance edge
  task automatic accept_word(input logic [W-1:0] g, output int acc_cyc);
    bit took;
    int n;
`ifdef G2B_STEP_CHECK_EN
    bit exp_step;
`endif
    in_valid = 1'b1;
    in_gray  = g;
    took     = 1'b0;
    n        = 0;
    while (!took && n < 40) begin
      took = in_ready;
      step();
      n++;
    end
    chk("accept_timeout", 32'(took), 1);
    acc_cyc = cyc;
    chk("in_ready_drop", 32'(in_ready), 0);
    chk("busy_conv", 32'(busy), 1);
`ifdef G2B_STEP_CHECK_EN
    exp_step  = have_prev && ($countones(g ^ prev_g) >= 2);
    prev_g    = g;
    have_prev = 1'b1;
    chk("step_err_pulse", 32'(step_err), 32'(exp_step));
`endif
    in_gray = W'($urandom);
  endtask

  task automatic xfer(input logic [W-1:0] g, input int stall, input bit chk_space);
    int acc_cyc;
    int n;
    logic [W-1:0] expb;
    expb      = g2b(g);
    out_ready = (stall == 0);
    accept_word(g, acc_cyc);
    if (chk_space) chk("spacing", 32'(acc_cyc - last_acc), W + 2);
    last_acc = acc_cyc;
    n = 0;
    while (!out_valid && n < int'(W) + 8) begin
      in_valid = 1'($urandom);
      in_gray  = W'($urandom);
      step();
`ifdef G2B_STEP_CHECK_EN
      if (n == 0) chk("step_err_clear", 32'(step_err), 0);
`endif
      n++;
    end
    chk("latency", 32'(n), W);
    chk("out_binary", 32'(out_binary), 32'(expb));
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      in_gray  = W'($urandom);
      step();
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", 32'(out_binary), 32'(expb));
      chk("hold_no_accept", 32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("release_valid", 32'(out_valid), 0);
    chk("release_ready", 32'(in_ready), 1);
    chk("release_busy", 32'(busy), 0);
    chk("out_binary_kept", 32'(out_binary), 32'(expb));
  endtask

  initial begin
    int a;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_gray   = '0;
    out_ready = 1'b0;
`ifdef G2B_STEP_CHECK_EN
    prev_g    = '0;
    have_prev = 1'b0;
`endif
    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_binary", 32'(out_binary), 0);
    chk("rst_busy", 32'(busy), 0);
`ifdef G2B_STEP_CHECK_EN
    chk("rst_step_err", 32'(step_err), 0);
`endif
    rst_n = 1'b1;
    chk("ready_before_edge", 32'(in_ready), 0);
    step();
    chk("ready_after_release", 32'(in_ready), 1);

    // Scenario 1: single word, 1110 -> 1011
    xfer(4'b1110, 0, 1'b0);
    chk("s1_result_1011", 32'(out_binary), 32'h0000_000b);

    // Scenario 2: back-to-back words, spacing WIDTH+2
    xfer(4'b0100, 0, 1'b0);
    xfer(4'b0111, 0, 1'b1);
    xfer(4'b1010, 0, 1'b1);
    xfer(4'b1000, 0, 1'b1);
    chk("s2_last_1111", 32'(out_binary), 32'h0000_000f);

    // Scenario 3: output stall with competing input traffic
    xfer(4'b1110, 10, 1'b0);

    // Scenario 4: reset in the middle of a conversion
    accept_word(4'b1000, a);
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_in_ready", 32'(in_ready), 0);
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_out_binary", 32'(out_binary), 0);
    chk("async_busy", 32'(busy), 0);
`ifdef G2B_STEP_CHECK_EN
    chk("async_step_err", 32'(step_err), 0);
    prev_g    = '0;
    have_prev = 1'b0;
`endif
    step();
    rst_n = 1'b1;
    chk("rerst_ready_low", 32'(in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("no_stale_valid", 32'(out_valid), 0);
      chk("rerst_ready_high", 32'(in_ready), 1);
    end
    xfer(4'b0000, 0, 1'b0);

    // Scenarios 5/6: step-check sequence
    xfer(4'b0000, 0, 1'b1);
    xfer(4'b0001, 0, 1'b1);
    xfer(4'b0011, 0, 1'b1);
    xfer(4'b1010, 0, 1'b1);
    chk("s5_last_1100", 32'(out_binary), 32'h0000_000c);

    // Randomized words with random output stalls
    for (int r = 0; r < 40; r++) begin
      int st;
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      xfer(W'($urandom), st, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/g2b_serial_decoder.md
Name: g2b_serial_decoder

Overview:
- Gray-to-binary decoder, the receive-side counterpart of the team's binary-to-Gray converter.
- Accepts one WIDTH-bit Gray word over a valid/ready handshake and resolves it to binary serially, MSB first, one bit per clock.
- Presents the result on an output valid/ready handshake.
- Sits behind Gray-coded sources such as position encoders and CDC pointer buses.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_gray holds a valid word
- in_ready  output  1  block can accept a word
- in_gray  input  WIDTH  Gray-coded input word
- out_valid  output  1  out_binary holds a valid result
- out_ready  input  1  downstream consumes the result
- out_binary  output  WIDTH  decoded binary word
- busy  output  1  high in CONV or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready=0, out_valid=0, out_binary=0, busy=0; internal shift register, bit counter and previous-word register cleared.
- First rising edge after rst_n deasserts: in_ready goes to 1.
- Partial conversions interrupted by reset are discarded; no output is produced for them.
- States: IDLE, CONV, DONE. All outputs are registered.
- IDLE: in_ready=1.
  - On an edge with in_valid&&in_ready: latch in_gray, set bit index to WIDTH-1, clear the running result, drop in_ready, go to CONV.
  - in_valid without a handshake is ignored.
- CONV: one bit per edge, from i=WIDTH-1 down to 0.
  - b[WIDTH-1]=g[WIDTH-1].
  - b[i]=b[i+1]^g[i] for i<WIDTH-1.
  - After the edge resolving bit 0, load out_binary, set out_valid=1, go to DONE.
- Latency: out_valid rises exactly WIDTH clocks after the acceptance edge.
- DONE: out_valid=1; out_binary held stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1: out_valid=0, in_ready=1, go to IDLE.
- Throughput: at most one word per WIDTH+2 clocks.
- in_gray changes after the acceptance edge do not affect the word in flight.
- out_ready while out_valid=0 is ignored.
- in_valid while in_ready=0 is ignored.
- out_binary keeps its last value after the output handshake until the next result is loaded.
- Arithmetic is XOR only; no width growth; all bit positions are used, no wrap.

Optional Feature:
- Macro: G2B_STEP_CHECK_EN.
- Defined:
  - Adds output port step_err (1 bit, reset 0).
  - On each acceptance edge after the first accepted word since reset, compute popcount(in_gray ^ previously accepted Gray word).
  - If the popcount is 2 or more, step_err pulses high for exactly one clock, on the edge after acceptance.
  - A popcount of 0 or 1 is legal.
  - The previous-word register updates on every acceptance.
  - The first word after reset is never flagged.
  - Conversion proceeds normally regardless of step_err.
- Undefined: no step_err port, no previous-word register, no comparison logic.

Test Plan:
1. WIDTH=4; reset low, then release; send 1110; out_ready=1 -> in_ready=1 one clock after release; out_valid rises 4 clocks after acceptance; out_binary=1011.
2. Back-to-back words 0100, 0111, 1010, 1000 with in_valid held high -> results 0111, 0101, 1100, 1111 in order; each accepted only when in_ready=1; spacing 6 clocks.
3. Send 1110 and hold out_ready=0 for 10 clocks -> out_valid=1 and out_binary=1011 stable throughout; a new in_valid is not accepted. Raise out_ready -> IDLE the next clock.
4. Send 1000 and assert rst_n low two clocks into CONV -> all outputs 0 immediately (asynchronously). After release, send 0000 -> out_binary=0000, with no stale result emitted.
5. With G2B_STEP_CHECK_EN defined: send 0000, 0001, 0011, 1010 -> step_err pulses only for 1010 (popcount 2); binary results 0000, 0001, 0010, 1100.
6. Without the macro: identical stimulus to scenario 5 -> same binary results; build has no step_err port.
